// File: rtl/i2c_register_transaction_master.sv
// I2C master running one register transaction per request: pointer write,
// optional repeated-START read or data write, with NACK abort to STOP.
`timescale 1ns/1ps
module i2c_register_transaction_master #(
    parameter int CLOCK_DIVIDE = 4,
    parameter int MAX_BYTES    = 4,
    parameter int COUNT_WIDTH  = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start_transfer,
    input  logic                   read_not_write,
    input  logic [6:0]             address,
    input  logic [7:0]             register_address,
    input  logic [COUNT_WIDTH-1:0] byte_count,
    input  logic [8*MAX_BYTES-1:0] write_data,
    output logic [8*MAX_BYTES-1:0] read_data,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_error,
    output logic                   scl,
    output logic                   sda_out,
    output logic                   sda_dir,
    input  logic                   sda_in
);
    localparam int DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [DIV_W-1:0]       DIV_ONE  = DIV_W'(1);
    localparam logic [COUNT_WIDTH-1:0] MAX_CNT  = COUNT_WIDTH'(MAX_BYTES);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_REG, S_WDATA, S_RSTART,
        S_ADDR_R, S_RDATA, S_ACK, S_MACK, S_STOP, S_DONE
    } state_t;

    state_t                   state_q, state_d, from_q, from_d;
    logic [DIV_W-1:0]         div_q;
    logic [1:0]               qtr_q;
    logic [2:0]               bit_q;
    logic [COUNT_WIDTH-1:0]   byte_q, count_q;
    logic                     rnw_q, nack_q, ack_error_q;
    logic [6:0]               addr_q;
    logic [7:0]               reg_q, rx_q, tx_byte;
    logic [8*MAX_BYTES-1:0]   wdata_q, rdata_q;
    logic                     tick_end, sample_pt, bit_end, last_bit, last_byte, data_scl, byte_state;

    assign tick_end   = (div_q == DIV_LAST);
    assign sample_pt  = tick_end && (qtr_q == 2'd1);
    assign bit_end    = tick_end && (qtr_q == 2'd3);
    assign last_bit   = (bit_q == 3'd7);
    assign last_byte  = ((byte_q + CNT_ONE) == count_q);
    assign data_scl   = (qtr_q == 2'd1) || (qtr_q == 2'd2);
    assign byte_state = (state_q == S_ADDR_W) || (state_q == S_REG) || (state_q == S_WDATA) ||
                        (state_q == S_ADDR_R) || (state_q == S_RDATA);

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign ack_error = ack_error_q;
    assign read_data = rdata_q;

    always_comb begin
        tx_byte = 8'hFF;
        case (state_q)
            S_ADDR_W: tx_byte = {addr_q, 1'b0};
            S_ADDR_R: tx_byte = {addr_q, 1'b1};
            S_REG:    tx_byte = reg_q;
            S_WDATA:  tx_byte = wdata_q[int'(byte_q)*8 +: 8];
            default:  tx_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            from_q  <= S_IDLE;
        end else begin
            state_q <= state_d;
            from_q  <= from_d;
        end
    end

    always_comb begin
        state_d = state_q;
        from_d  = from_q;
        scl     = 1'b1;
        sda_out = 1'b1;
        sda_dir = 1'b1;
        case (state_q)
            S_IDLE:   if (start_transfer) state_d = S_START;
            S_START: begin
                sda_out = (qtr_q == 2'd0);
                scl     = (qtr_q <= 2'd1);
                if (bit_end) state_d = S_ADDR_W;
            end
            S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
                scl     = data_scl;
                sda_out = tx_byte[3'd7 - bit_q];
                if (bit_end && last_bit) begin
                    state_d = S_ACK;
                    from_d  = state_q;
                end
            end
            S_RDATA: begin
                scl     = data_scl;
                sda_dir = 1'b0;
                if (bit_end && last_bit) state_d = S_MACK;
            end
            S_ACK: begin
                scl     = data_scl;
                sda_dir = 1'b0;
                if (bit_end) begin
                    if (nack_q) state_d = S_STOP;
                    else begin
                        case (from_q)
                            S_ADDR_W: state_d = S_REG;
                            S_REG:    state_d = (count_q == '0) ? S_STOP : (rnw_q ? S_RSTART : S_WDATA);
                            S_WDATA:  state_d = last_byte ? S_STOP : S_WDATA;
                            S_ADDR_R: state_d = S_RDATA;
                            default:  state_d = S_STOP;
                        endcase
                    end
                end
            end
            S_MACK: begin
                scl     = data_scl;
                sda_out = last_byte;
                if (bit_end) state_d = last_byte ? S_STOP : S_RDATA;
            end
            S_RSTART: begin
                sda_out = (qtr_q <= 2'd1);
                scl     = data_scl;
                if (bit_end) state_d = S_ADDR_R;
            end
            S_STOP: begin
                sda_out = (qtr_q >= 2'd2);
                scl     = (qtr_q != 2'd0);
                if (bit_end) state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Timing counters restart at accept so every transaction begins on a quarter boundary.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            count_q     <= '0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rx_q        <= '0;
            nack_q      <= 1'b0;
            ack_error_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            div_q  <= '0;
            qtr_q  <= '0;
            bit_q  <= '0;
            byte_q <= '0;
            if (start_transfer) begin
                rnw_q       <= read_not_write;
                addr_q      <= address;
                reg_q       <= register_address;
                wdata_q     <= write_data;
                count_q     <= (byte_count > MAX_CNT) ? MAX_CNT : byte_count;
                ack_error_q <= 1'b0;
                if (read_not_write) rdata_q <= '0;
            end
        end else if (busy) begin
            div_q <= tick_end ? '0 : div_q + DIV_ONE;
            if (tick_end) qtr_q <= qtr_q + 2'd1;
            if (bit_end) bit_q <= byte_state ? bit_q + 3'd1 : 3'd0;
            if (sample_pt && state_q == S_RDATA) rx_q <= {rx_q[6:0], sda_in};
            if (sample_pt && state_q == S_ACK) nack_q <= sda_in;
            if (bit_end && last_bit && state_q == S_RDATA) rdata_q[int'(byte_q)*8 +: 8] <= rx_q;
            if (bit_end && state_q == S_ACK) begin
                if (nack_q) ack_error_q <= 1'b1;
                else if (from_q == S_WDATA) byte_q <= byte_q + CNT_ONE;
            end
            if (bit_end && state_q == S_MACK) byte_q <= byte_q + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_i2c_register_transaction_master.sv
// Directed bench: bus-level slave model decodes the SDA/SCL stream and answers
// ACK/NACK and read data; byte streams and timings are checked against hand values.
`timescale 1ns/1ps
module tb_i2c_register_transaction_master;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        start_transfer;
    logic        read_not_write;
    logic [6:0]  address;
    logic [7:0]  register_address;
    logic [2:0]  byte_count;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busy, done, ack_error, scl, sda_out, sda_dir;
    logic        sda_in = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] wr_obs[$];
    logic       mack_obs[$];
    logic [7:0] rd_src[$];
    int start_cnt = 0, stop_cnt = 0, dir_bad = 0, nack_at = -1;
    int bit_cnt = 0, frame_byte = 0, rd_ptr = 0;
    bit reading = 1'b0, pending = 1'b0;
    logic bit_val = 1'b1, bit_dir = 1'b1, prev_scl = 1'b1, prev_line = 1'b1;
    logic [7:0] cur = '0;

    i2c_register_transaction_master #(.CLOCK_DIVIDE(4), .MAX_BYTES(4), .COUNT_WIDTH(3)) dut (
        .clock(clock), .reset_n(reset_n), .start_transfer(start_transfer),
        .read_not_write(read_not_write), .address(address), .register_address(register_address),
        .byte_count(byte_count), .write_data(write_data), .read_data(read_data),
        .busy(busy), .done(done), .ack_error(ack_error), .scl(scl),
        .sda_out(sda_out), .sda_dir(sda_dir), .sda_in(sda_in)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: a bit is committed on the SCL fall so START/STOP pulses are not mistaken for data.
    always @(negedge clock) begin
        logic ln;
        logic [7:0] src;
        bit rb;
        ln = sda_dir ? sda_out : sda_in;
        if (scl && prev_scl && prev_line && !ln) begin
            start_cnt++; bit_cnt = 0; frame_byte = 0; reading = 1'b0; pending = 1'b0;
        end else if (scl && prev_scl && !prev_line && ln) begin
            stop_cnt++; bit_cnt = 0; pending = 1'b0;
        end else if (scl && !prev_scl) begin
            pending = 1'b1; bit_val = ln; bit_dir = sda_dir;
        end else if (!scl && prev_scl) begin
            rb = reading && (frame_byte > 0);
            if (pending) begin
                if (bit_cnt < 8) begin
                    cur = {cur[6:0], bit_val};
                    bit_cnt++;
                    if (bit_dir == rb) dir_bad++;
                end else begin
                    if (rb) begin
                        mack_obs.push_back(bit_val);
                        rd_ptr++;
                    end else begin
                        wr_obs.push_back(cur);
                        if (frame_byte == 0) reading = cur[0];
                    end
                    if (bit_dir != rb) dir_bad++;
                    bit_cnt = 0;
                    frame_byte++;
                end
                pending = 1'b0;
            end
            rb = reading && (frame_byte > 0);
            if (bit_cnt == 8) sda_in = rb ? 1'b1 : ((wr_obs.size() == nack_at) ? 1'b1 : 1'b0);
            else if (rb) begin
                src = (rd_ptr < rd_src.size()) ? rd_src[rd_ptr] : 8'hFF;
                sda_in = src[7-bit_cnt];
            end else sda_in = 1'b1;
        end
        prev_scl = scl;
        prev_line = ln;
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 0; k < 5000 && !done; k++) begin
            if (busy) cyc++;
            @(negedge clock);
        end
        check_eq("done_seen", done, 1);
    endtask

    task automatic run_txn(input bit rnw, input logic [6:0] a, input logic [7:0] r, input logic [2:0] cnt,
                           input logic [31:0] wd, input int nack_rel, input int exp_busy,
                           input int exp_starts, input logic exp_err);
        int base, sbase, pbase, dbase, cyc, n;
        base = wr_obs.size(); sbase = start_cnt; pbase = stop_cnt; dbase = dir_bad;
        nack_at = (nack_rel < 0) ? -1 : base + nack_rel;
        @(negedge clock);
        read_not_write = rnw; address = a; register_address = r;
        byte_count = cnt; write_data = wd; start_transfer = 1'b1;
        @(negedge clock);
        start_transfer = 1'b0; address = 7'h7F; register_address = 8'hFF;
        write_data = '1; read_not_write = ~rnw; byte_count = 3'd5;
        check_eq("busy_after_accept", busy, 1);
        check_eq("ack_error_cleared", ack_error, 0);
        wait_done(cyc);
        check_eq("busy_cycles", cyc, exp_busy);
        check_eq("busy_low_with_done", busy, 0);
        check_eq("ack_error", ack_error, exp_err);
        @(negedge clock);
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_scl", scl, 1);
        check_eq("idle_sda", {sda_out, sda_dir}, 2'b11);
        check_eq("start_count", start_cnt - sbase, exp_starts);
        check_eq("stop_count", stop_cnt - pbase, 1);
        check_eq("sda_dir_per_slot", dir_bad - dbase, 0);
        n = exp_q.size();
        check_eq("wr_byte_count", wr_obs.size() - base, n);
        for (int i = 0; i < n; i++)
            check_eq($sformatf("wr_byte%0d", i),
                     (base + i < wr_obs.size()) ? {56'h0, wr_obs[base+i]} : 64'h100, {56'h0, exp_q[i]});
        exp_q.delete();
    endtask

    initial begin
        int mb, cyc, base;
        reset_n = 1'b0; start_transfer = 1'b0; read_not_write = 1'b0; address = '0;
        register_address = '0; byte_count = '0; write_data = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_scl", scl, 1);
        check_eq("rst_sda_out", sda_out, 1);
        check_eq("rst_sda_dir", sda_dir, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ack_error", ack_error, 0);
        check_eq("rst_read_data", read_data, 0);
        reset_n = 1'b1;

        // Write 0x48 / reg 0x01 / 0xBEEF
        exp_q.push_back(8'h90); exp_q.push_back(8'h01); exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        run_txn(1'b0, 7'h48, 8'h01, 3'd2, 32'h0000BEEF, -1, 608, 1, 1'b0);

        // Read four bytes with repeated START
        rd_src.push_back(8'h11); rd_src.push_back(8'h22); rd_src.push_back(8'h33); rd_src.push_back(8'h44);
        mb = mack_obs.size();
        exp_q.push_back(8'hA0); exp_q.push_back(8'h10); exp_q.push_back(8'hA1);
        run_txn(1'b1, 7'h50, 8'h10, 3'd4, 32'h0, -1, 1056, 2, 1'b0);
        check_eq("read_data", read_data, 32'h44332211);
        check_eq("mack_count", mack_obs.size() - mb, 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("mack%0d", i), (mb + i < mack_obs.size()) ? {63'h0, mack_obs[mb+i]} : 64'h2,
                     (i == 3) ? 64'h1 : 64'h0);

        // Address NACK on a read: abort, read_data cleared at accept
        exp_q.push_back(8'h78);
        run_txn(1'b1, 7'h3C, 8'h22, 3'd2, 32'h0, 0, 176, 1, 1'b1);
        check_eq("nack_read_data", read_data, 32'h0);

        // Register-byte NACK on a write
        exp_q.push_back(8'h90); exp_q.push_back(8'h02);
        run_txn(1'b0, 7'h48, 8'h02, 3'd2, 32'h0000BEEF, 1, 320, 1, 1'b1);

        // byte_count 7 clamps to 4
        exp_q.push_back(8'h54); exp_q.push_back(8'h7E); exp_q.push_back(8'h11);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        run_txn(1'b0, 7'h2A, 8'h7E, 3'd7, 32'h44332211, -1, 896, 1, 1'b0);

        // Read of zero bytes is a pointer write only
        exp_q.push_back(8'hA6); exp_q.push_back(8'h05);
        run_txn(1'b1, 7'h53, 8'h05, 3'd0, 32'h0, -1, 320, 1, 1'b0);

        // Asynchronous reset during the first data byte (SCL low, SDA low)
        nack_at = -1;
        @(negedge clock);
        read_not_write = 1'b0; address = 7'h48; register_address = 8'h33;
        byte_count = 3'd4; write_data = 32'h0; start_transfer = 1'b1;
        @(negedge clock);
        start_transfer = 1'b0;
        repeat (316) @(negedge clock);
        #3 reset_n = 1'b0;
        #1;
        check_eq("async_rst_scl", scl, 1);
        check_eq("async_rst_sda_out", sda_out, 1);
        check_eq("async_rst_sda_dir", sda_dir, 1);
        check_eq("async_rst_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back(8'h90); exp_q.push_back(8'h33); exp_q.push_back(8'h5A);
        run_txn(1'b0, 7'h48, 8'h33, 3'd1, 32'h0000005A, -1, 464, 1, 1'b0);

        // start_transfer held high: NACKed transaction then a clean one back to back
        base = wr_obs.size();
        nack_at = base;
        @(negedge clock);
        read_not_write = 1'b0; address = 7'h21; register_address = 8'h44;
        byte_count = 3'd1; write_data = 32'h99; start_transfer = 1'b1;
        @(negedge clock);
        wait_done(cyc);
        check_eq("b2b_first_busy", cyc, 176);
        check_eq("b2b_first_err", ack_error, 1);
        nack_at = -1;
        @(negedge clock);
        check_eq("b2b_idle_gap", busy, 0);
        @(negedge clock);
        check_eq("b2b_accept", busy, 1);
        check_eq("b2b_err_cleared", ack_error, 0);
        wait_done(cyc);
        check_eq("b2b_second_busy", cyc, 464);
        check_eq("b2b_second_err", ack_error, 0);
        start_transfer = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("b2b_no_third", busy, 0);
        check_eq("b2b_bytes", wr_obs.size() - base, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/i2c_register_transaction_master.md
Name: i2c_register_transaction_master

Overview:
- Parametrised I2C master performing one complete register transaction per request.
- Write mode: START, addr+W, register pointer, 0..MAX_BYTES data bytes, STOP.
- Read mode: START, addr+W, register pointer, repeated START, addr+R, 1..MAX_BYTES data bytes, STOP.
- Sits between sensor/config controllers and the open-drain pad (scl, sda_out/sda_dir/sda_in), with a programmable bit rate and NACK abort.

Parameters:
- CLOCK_DIVIDE, 4, system clocks per quarter SCL bit period (Q); must be >=1.
- MAX_BYTES, 4, maximum data bytes per transaction.
- COUNT_WIDTH, 3, width of byte_count; must hold MAX_BYTES.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- start_transfer  in  1  request; accepted only when idle.
- read_not_write  in  1  1=read transaction, 0=write.
- address  in  7  slave address.
- register_address  in  8  register pointer byte.
- byte_count  in  COUNT_WIDTH  data bytes to transfer; values above MAX_BYTES are clamped.
- write_data  in  8*MAX_BYTES  byte k at [8k+7:8k]; byte 0 is sent first.
- read_data  out  8*MAX_BYTES  byte k at [8k+7:8k]; byte 0 is received first.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at end of transaction.
- ack_error  out  1  slave NACKed (sticky until next accept).
- scl  out  1  SCL drive.
- sda_out  out  1  SDA drive value.
- sda_dir  out  1  1=drive SDA, 0=release/input.
- sda_in  in  1  SDA pad input.

Behaviour:
- Reset (async, any time, including mid-transaction): scl=1, sda_out=1, sda_dir=1, busy=0, done=0, ack_error=0, read_data=0, FSM=IDLE. Held there until reset_n deasserts.
- IDLE:
  - start_transfer=1 latches all inputs; busy=1, ack_error=0 next cycle.
  - In read mode, read_data is cleared at accept.
  - start_transfer while busy is ignored; inputs may change after accept.
- Bit timing: every bit, START, repeated START and STOP is 4 quarters of CLOCK_DIVIDE clocks each.
- Data bit quarters:
  - Q0: scl=0, SDA set up.
  - Q1, Q2: scl=1; sda_in sampled on the last clock of Q1.
  - Q3: scl=0.
- START: Q0 SDA=1, SCL=1; Q1 SDA=0; Q2-Q3 SCL=0.
- Repeated START: Q0 SDA=1 with SCL=0; Q1 SCL=1; Q2 SDA=0; Q3 SCL=0.
- STOP: Q0 SDA=0, SCL=0; Q1 SCL=1; Q2-Q3 SDA=1.
- Bytes are transferred MSB first.
- Slave ACK bit: sda_dir=0 for the whole bit; sampled 1 is a NACK.
- Master ACK/NACK on reads: sda_dir=1; sda_out=0 after every byte except the last, sda_out=1 after the last.
- FSM: IDLE -> START -> ADDR_W -> ACK -> REG -> ACK -> {WDATA -> ACK}*N -> STOP -> DONE (write). Read path: after the REG ACK -> RSTART -> ADDR_R -> ACK -> {RDATA -> MACK}*N -> STOP -> DONE.
- Read with byte_count=0: performs the pointer write only (START, addr+W, reg, STOP); no repeated START.
- Write with byte_count=0: pointer-only write.
- NACK on any slave ACK bit: ack_error=1, skip all remaining bits, go directly to STOP then DONE. read_data bytes already received are kept; later bytes stay 0.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE. A new start_transfer is accepted in the cycle after done.
- Duration, busy high, no NACK, N=clamped count, D=CLOCK_DIVIDE:
  - Write: 4D*(20+9N) cycles.
  - Read N>=1: 4D*(30+9N) cycles.
- read_data byte k updates at the end of its 8th bit; outputs are otherwise stable.
- Idle outputs: scl=1, sda_out=1, sda_dir=1.

Test Plan:
- D=4, write, address=0x48, reg=0x01, count=2, write_data=0xBEEF, slave ACKs all -> SDA bit stream 0x90,0x01,0xEF,0xBE with ACK slots released; busy high 608 cycles; done pulse; ack_error=0.
- D=4, read, address=0x50, reg=0x10, count=4, slave returns 0x11,0x22,0x33,0x44 -> read_data=0x44332211; master ACK,ACK,ACK,NACK; repeated START seen; busy 1056 cycles.
- Slave NACKs the address byte -> ack_error=1, STOP immediately after the ACK bit, done pulses, busy high 4D*11 cycles, read_data=0.
- byte_count=7 with MAX_BYTES=4 write -> exactly 4 data bytes sent; byte_count=0 read -> pointer write only, 4D*20 cycles, no repeated START.
- reset_n pulsed low mid data byte -> scl, sda_out and sda_dir go to 1 asynchronously and busy=0; the next start_transfer runs a clean full transaction.
- start_transfer held high continuously -> back-to-back transactions, each accepted the cycle after done, ack_error cleared on each accept.
